// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: RV32I/RV64I immediate decode behind a 2-entry skid buffer.
// Latency 1 cycle into an empty buffer; in_ready is registered and drops only when both entries are full.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       fmt,
    output logic             illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;
    localparam logic [2:0] FMT_CSR   = 3'd7;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh, imm_csr;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;

    logic [XLEN-1:0]  tail_imm;
    logic [2:0]       tail_fmt;
    logic             tail_illegal;
    logic [TAG_W-1:0] tail_tag;

    logic take, give;

    // Every format is built up front; the opcode only selects among them.
    assign imm_i   = XLEN'($signed(instr[31:20]));
    assign imm_s   = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign imm_b   = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    assign imm_u   = XLEN'($signed({instr[31:12], 12'b0}));
    assign imm_j   = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
    assign imm_sh  = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
    assign imm_csr = XLEN'(instr[31:20]);

    always_comb begin
        dec_imm     = '0;
        dec_fmt     = FMT_NONE;
        dec_illegal = 1'b0;
        if (instr[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end else begin
            case (instr[6:0])
                OP_LOAD, OP_JALR: begin
                    dec_imm = imm_i;
                    dec_fmt = FMT_I;
                end
                OP_IMM: begin
                    // funct3 001 (SLLI) and 101 (SRLI/SRAI) carry a shift amount
                    if (instr[13:12] == 2'b01) begin
                        dec_imm = imm_sh;
                        dec_fmt = FMT_SHAMT;
                    end else begin
                        dec_imm = imm_i;
                        dec_fmt = FMT_I;
                    end
                end
                OP_STORE: begin
                    dec_imm = imm_s;
                    dec_fmt = FMT_S;
                end
                OP_BRANCH: begin
                    dec_imm = imm_b;
                    dec_fmt = FMT_B;
                end
                OP_LUI, OP_AUIPC: begin
                    dec_imm = imm_u;
                    dec_fmt = FMT_U;
                end
                OP_JAL: begin
                    dec_imm = imm_j;
                    dec_fmt = FMT_J;
                end
                OP_SYSTEM: begin
                    dec_imm = imm_csr;
                    dec_fmt = FMT_CSR;
                end
                OP_OP, OP_FENCE: begin
                    dec_fmt = FMT_NONE;
                end
                default: begin
                    dec_illegal = 1'b1;
                end
            endcase
        end
    end

    assign out_valid = (state != EMPTY);
    assign take      = in_valid && in_ready;
    assign give      = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = EMPTY;
        end else begin
            case (state)
                EMPTY: if (take) state_nx = ONE;
                ONE: begin
                    if (take && !give) state_nx = FULL;
                    else if (give && !take) state_nx = EMPTY;
                end
                FULL: if (give) state_nx = ONE;
                default: state_nx = EMPTY;
            endcase
        end
    end

    // Head registers drive the outputs directly; the tail only fills when the head is stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready     <= 1'b0;
            imm          <= '0;
            fmt          <= FMT_NONE;
            illegal      <= 1'b0;
            out_tag      <= '0;
            tail_imm     <= '0;
            tail_fmt     <= FMT_NONE;
            tail_illegal <= 1'b0;
            tail_tag     <= '0;
        end else begin
            in_ready <= (state_nx != FULL);
            if (flush) begin
                imm     <= '0;
                fmt     <= FMT_NONE;
                illegal <= 1'b0;
                out_tag <= '0;
            end else begin
                case (state)
                    EMPTY: begin
                        if (take) begin
                            imm     <= dec_imm;
                            fmt     <= dec_fmt;
                            illegal <= dec_illegal;
                            out_tag <= in_tag;
                        end
                    end
                    ONE: begin
                        if (take && give) begin
                            imm     <= dec_imm;
                            fmt     <= dec_fmt;
                            illegal <= dec_illegal;
                            out_tag <= in_tag;
                        end else if (take) begin
                            tail_imm     <= dec_imm;
                            tail_fmt     <= dec_fmt;
                            tail_illegal <= dec_illegal;
                            tail_tag     <= in_tag;
                        end else if (give) begin
                            imm     <= '0;
                            fmt     <= FMT_NONE;
                            illegal <= 1'b0;
                            out_tag <= '0;
                        end
                    end
                    FULL: begin
                        if (give) begin
                            imm     <= tail_imm;
                            fmt     <= tail_fmt;
                            illegal <= tail_illegal;
                            out_tag <= tail_tag;
                        end
                    end
                    default: begin
                        imm <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus and are checked
// every cycle against a queue-based model plus directed literal expectations.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] instr, in_tag;

    logic        rdy32, rdy64, v32, v64, ill32, ill64;
    logic [31:0] imm32, tag32, tag64;
    logic [63:0] imm64;
    logic [2:0]  fmt32, fmt64;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .instr(instr), .in_tag(in_tag), .out_valid(v32), .out_ready(out_ready),
        .imm(imm32), .fmt(fmt32), .illegal(ill32), .out_tag(tag32));

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .instr(instr), .in_tag(in_tag), .out_valid(v64), .out_ready(out_ready),
        .imm(imm64), .fmt(fmt64), .illegal(ill64), .out_tag(tag64));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    // Immediate value computed arithmetically from the field weights of each format.
    function automatic void ref_dec(input logic [31:0] w, input int xl,
                                    output logic [63:0] imm, output logic [2:0] fmt,
                                    output logic ill);
        longint sgn, v;
        int s;
        s   = w;
        sgn = w[31] ? -64'sd1 : 64'sd0;
        v   = 0;
        fmt = 3'd0;
        ill = 1'b0;
        if (w[1:0] != 2'b11) begin
            ill = 1'b1;
        end else begin
            case (w[6:0])
                7'h03, 7'h67: begin v = longint'(s >>> 20); fmt = 3'd1; end
                7'h13: begin
                    if (w[14:12] == 3'b001 || w[14:12] == 3'b101) begin
                        v = (xl == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
                        fmt = 3'd6;
                    end else begin
                        v = longint'(s >>> 20);
                        fmt = 3'd1;
                    end
                end
                7'h23: begin
                    v = sgn * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:7]);
                    fmt = 3'd2;
                end
                7'h63: begin
                    v = sgn * 4096 + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
                        + longint'(w[11:8]) * 2;
                    fmt = 3'd3;
                end
                7'h37, 7'h17: begin
                    v = sgn * 64'sd2147483648 + longint'(w[30:12]) * 4096;
                    fmt = 3'd4;
                end
                7'h6F: begin
                    v = sgn * 1048576 + longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048
                        + longint'(w[30:21]) * 2;
                    fmt = 3'd5;
                end
                7'h73: begin v = longint'(w[31:20]); fmt = 3'd7; end
                7'h33, 7'h0F: begin end
                default: ill = 1'b1;
            endcase
        end
        imm = (xl == 32) ? {32'h0, v[31:0]} : v;
    endfunction

    typedef struct {
        logic [31:0] ins;
        logic [31:0] tag;
    } ent_t;

    ent_t q[$];
    bit   rdy_m = 1'b0;

    always @(posedge clk) begin
        bit pop, push;
        if (!rst_n) begin
            q.delete();
            rdy_m = 1'b0;
        end else begin
            if (flush) begin
                q.delete();
            end else begin
                pop  = (q.size() > 0) && out_ready;
                push = in_valid && rdy_m;
                if (pop) void'(q.pop_front());
                if (push) q.push_back('{ins: instr, tag: in_tag});
            end
            rdy_m = (q.size() < 2);
        end
    end

    always @(negedge clk) begin
        logic [63:0] e;
        logic [2:0]  f;
        logic        il;
        chk("vld32", {63'b0, v32}, {63'b0, q.size() > 0});
        chk("vld64", {63'b0, v64}, {63'b0, q.size() > 0});
        chk("rdy32", {63'b0, rdy32}, {63'b0, rdy_m});
        chk("rdy64", {63'b0, rdy64}, {63'b0, rdy_m});
        if (q.size() > 0) begin
            ref_dec(q[0].ins, 32, e, f, il);
            chk("imm32", {32'h0, imm32}, e);
            chk("fmt32", {61'b0, fmt32}, {61'b0, f});
            chk("ill32", {63'b0, ill32}, {63'b0, il});
            chk("tag32", {32'h0, tag32}, {32'h0, q[0].tag});
            ref_dec(q[0].ins, 64, e, f, il);
            chk("imm64", imm64, e);
            chk("fmt64", {61'b0, fmt64}, {61'b0, f});
            chk("ill64", {63'b0, ill64}, {63'b0, il});
            chk("tag64", {32'h0, tag64}, {32'h0, q[0].tag});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] w, input logic [31:0] t);
        in_valid = 1'b1;
        instr    = w;
        in_tag   = t;
    endtask

    logic [63:0] pe;
    logic [2:0]  pf;
    logic        pi;
    logic [31:0] r;
    logic [6:0]  ops[12] = '{7'h03, 7'h67, 7'h13, 7'h23, 7'h63, 7'h37,
                             7'h17, 7'h6F, 7'h73, 7'h33, 7'h0F, 7'h7F};

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; in_tag = '0;

        ref_dec(32'hFFC12083, 64, pe, pf, pi);  chk("model_lw64", pe, 64'hFFFFFFFFFFFFFFFC);
        ref_dec(32'h800002B7, 64, pe, pf, pi);  chk("model_lui64", pe, 64'hFFFFFFFF80000000);
        ref_dec(32'hFE000FE3, 32, pe, pf, pi);  chk("model_beq", pe, 64'h00000000FFFFFFFE);
        ref_dec(32'h01F09093, 32, pe, pf, pi);  chk("model_slli", {pe[60:0], pf}, {61'd31, 3'd6});

        repeat (3) step();
        chk("rst_vld", {62'b0, v32, v64}, 64'h0);
        chk("rst_rdy", {62'b0, rdy32, rdy64}, 64'h0);
        chk("rst_imm", imm64 | {32'h0, imm32}, 64'h0);
        chk("rst_misc", {fmt32, fmt64, ill32, ill64, tag32, tag64}, 64'h0);
        rst_n = 1'b1;
        step();
        chk("rdy_after_rst", {62'b0, rdy32, rdy64}, 64'h3);

        // single load, both widths
        out_ready = 1'b1;
        offer(32'hFFC12083, 32'h100);
        step();
        in_valid = 1'b0;
        chk("lw_imm32", {32'h0, imm32}, 64'hFFFFFFFC);
        chk("lw_imm64", imm64, 64'hFFFFFFFFFFFFFFFC);
        chk("lw_fmt_ill", {60'b0, fmt32, ill32}, {60'b0, 3'd1, 1'b0});
        step();

        // back-to-back S, B, J, U
        offer(32'hFE112E23, 32'hA0); step();
        chk("b2b_s", {32'h0, imm32}, 64'hFFFFFFFC);
        offer(32'hFE000FE3, 32'hA1); step();
        chk("b2b_b", {32'h0, imm32}, 64'hFFFFFFFE);
        offer(32'h001000EF, 32'hA2); step();
        chk("b2b_j", {32'h0, imm32}, 64'h00000800);
        offer(32'h123452B7, 32'hA3); step();
        chk("b2b_u", {32'h0, imm32}, 64'h12345000);
        chk("b2b_tag", {32'h0, tag32}, 64'hA3);
        offer(32'h800002B7, 32'hA4); step();
        chk("lui64", imm64, 64'hFFFFFFFF80000000);

        // illegal / none, shift, csr
        offer(32'h0000007F, 32'hB0); step();
        chk("ill_7f", {imm32, 28'b0, fmt32, ill32}, 64'h1);
        offer(32'h00000001, 32'hB1); step();
        chk("ill_01", {imm32, 28'b0, fmt32, ill32}, 64'h1);
        offer(32'h00000033, 32'hB2); step();
        chk("none_op", {imm32, 28'b0, fmt32, ill32}, 64'h0);
        offer(32'h01F09093, 32'hB3); step();
        chk("slli", {imm32, 29'b0, fmt32}, {32'd31, 29'b0, 3'd6});
        offer(32'h300020F3, 32'hB4); step();
        chk("csrrs", {imm32, 29'b0, fmt32}, {32'h300, 29'b0, 3'd7});
        in_valid = 1'b0;
        step();

        // back-pressure: tags 1,2,3
        out_ready = 1'b0;
        offer(32'h00000013, 32'd1); step();
        offer(32'h00000013, 32'd2); step();
        offer(32'h00000013, 32'd3);
        chk("bp_rdy_low", {63'b0, rdy32}, 64'h0);
        step(); step();
        chk("bp_hold", {32'h0, tag32}, 64'd1);
        out_ready = 1'b1;
        step();
        chk("bp_tag2", {31'b0, v32, tag32}, {31'b0, 1'b1, 32'd2});
        step();
        in_valid = 1'b0;
        chk("bp_tag3", {31'b0, v32, tag32}, {31'b0, 1'b1, 32'd3});
        step();
        chk("bp_drain", {63'b0, v32}, 64'h0);

        // flush while full, with an input offered
        out_ready = 1'b0;
        offer(32'h00000013, 32'd10); step();
        offer(32'h00000013, 32'd11); step();
        offer(32'h00000013, 32'd12);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush_vld", {62'b0, v32, v64}, 64'h0);
        step(); step();
        chk("flush_no_emit", {62'b0, v32, v64}, 64'h0);

        // reset mid-stream
        out_ready = 1'b0;
        offer(32'hFFC12083, 32'd20); step();
        offer(32'h001000EF, 32'd21); step();
        rst_n = 1'b0;
        step();
        in_valid = 1'b0;
        chk("mid_rst_out", {imm32, tag32} | imm64, 64'h0);
        chk("mid_rst_ctl", {58'b0, v32, v64, rdy32, rdy64, ill32, ill64}, 64'h0);
        rst_n = 1'b1;
        step();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom();
            if ($urandom_range(0, 3) == 0) instr = r;
            else instr = {r[31:7], ops[$urandom_range(0, 11)]};
            in_tag    = $urandom();
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 49) == 0);
            rst_n     = ($urandom_range(0, 299) != 0);
            step();
        end
        in_valid = 1'b0; flush = 1'b0; rst_n = 1'b1; out_ready = 1'b1;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
